plic_gateway: RTL and testbench

PLIC_GATEWAY -- requirements
Module: plic_gateway

---
 rtl/plic_gateway.sv | 141 ++++++++++++++
 tb/tb_plic_gateway.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_gateway.sv
// plic_gateway -- per-source interrupt gateway for a PLIC.
//
// Each source slot 1..IRQ_NUM-1 turns a raw device line into one-cycle
// request pulses for the pending logic:
//   * level sources (tm_i=0) request while the line is high and idle;
//   * edge sources (tm_i=1) count rising edges in a saturating counter
//     and forward one edge per request/complete round trip.
// Slot 0 is reserved: its outputs are tied low and its inputs are ignored.
//
// Optional build macro: PLIC_GATEWAY_SYNC_EN
//   When defined, irq_i passes through a 2-flop synchronizer before it is
//   used. This adds 2 cycles of request latency (3 cycles instead of 1).
//
// Ports
//   clk_i      : clock, all state updates on the rising edge
//   rst_i      : synchronous active-high reset
//   irq_i      : raw interrupt lines, one per source
//   tm_i       : trigger mode per source, 1 = rising edge, 0 = high level
//   comp_i     : one-cycle completion pulse per source
//   ovf_clr_i  : one-cycle pulse that clears every ovf_o bit
//   req_o      : registered one-cycle request pulse per source
//   busy_o     : request forwarded and not yet completed
//   ovf_o      : sticky flag, an edge was lost on a saturated counter
module plic_gateway #(
  parameter int IRQ_NUM   = 32,
  parameter int CNT_WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] irq_i,
  input  logic [IRQ_NUM-1:0] tm_i,
  input  logic [IRQ_NUM-1:0] comp_i,
  input  logic               ovf_clr_i,
  output logic [IRQ_NUM-1:0] req_o,
  output logic [IRQ_NUM-1:0] busy_o,
  output logic [IRQ_NUM-1:0] ovf_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Slot 0 is reserved; its inputs only feed this sink.
  logic unused_slot0;
  assign unused_slot0 = irq_i[0] ^ tm_i[0] ^ comp_i[0];

  assign req_o[0]  = 1'b0;
  assign busy_o[0] = 1'b0;
  assign ovf_o[0]  = 1'b0;

  for (genvar i = 1; i < IRQ_NUM; i++) begin : g_src
    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 s_irq;
    logic                 s_prev_q;
    logic                 rise;
    logic                 issue;
    logic                 ovf_set;
    logic                 req_q;
    logic                 ovf_q;

    // Input sampling stage
`ifdef PLIC_GATEWAY_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
      end else begin
        sync1_q <= irq_i[i];
        sync2_q <= sync1_q;
      end
    end

    assign s_irq = sync2_q;
`else
    assign s_irq = irq_i[i];
`endif

    assign rise = s_irq & ~s_prev_q;

    // Request decision and edge counter update
    always_comb begin
      issue   = 1'b0;
      cnt_d   = cnt_q;
      ovf_set = 1'b0;
      if (!tm_i[i]) begin
        // Level mode never accumulates edges.
        cnt_d = '0;
        issue = (state_q == IDLE) && s_irq;
      end else begin
        issue = (state_q == IDLE) && (rise || (cnt_q != '0));
        if (issue) begin
          // A rise in the same cycle is the edge being consumed.
          if (!rise) begin
            cnt_d = cnt_q - 1'b1;
          end
        end else if (rise) begin
          if (cnt_q == CNT_MAX) begin
            ovf_set = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end

    // State register stage
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        s_prev_q <= 1'b0;
        req_q    <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        s_prev_q <= s_irq;
        cnt_q    <= cnt_d;
        req_q    <= issue;
        // A fresh overflow outranks a simultaneous clear.
        ovf_q    <= ovf_set | (ovf_q & ~ovf_clr_i);
        case (state_q)
          IDLE: if (issue) state_q <= BUSY;
          BUSY: if (comp_i[i]) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end

    assign req_o[i]  = req_q;
    assign busy_o[i] = (state_q == BUSY);
    assign ovf_o[i]  = ovf_q;
  end

endmodule

// File: tb/tb_plic_gateway.sv
module tb_plic_gateway;

  localparam int N    = 32;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef PLIC_GATEWAY_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] irq = '0;
  logic [N-1:0] tm = '0;
  logic [N-1:0] comp = '0;
  logic         ovf_clr = 1'b0;
  logic [N-1:0] req_o;
  logic [N-1:0] busy_o;
  logic [N-1:0] ovf_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state: edges owed per source, busy flags, sticky loss flags.
  int           owed [N];
  logic [N-1:0] m_busy = '0;
  logic [N-1:0] m_ovf  = '0;
  logic [N-1:0] m_req  = '0;
  logic [N-1:0] m_prev = '0;
  logic [N-1:0] m_sy1  = '0;
  logic [N-1:0] m_sy2  = '0;
  int           pulses [N];

  plic_gateway #(.IRQ_NUM(N), .CNT_WIDTH(CW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .irq_i     (irq),
    .tm_i      (tm),
    .comp_i    (comp),
    .ovf_clr_i (ovf_clr),
    .req_o     (req_o),
    .busy_o    (busy_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic [N-1:0] s;
    logic         r;
    logic         fire;
    int           total;
    if (rst) begin
      for (int i = 0; i < N; i++) owed[i] = 0;
      m_busy = '0; m_ovf = '0; m_req = '0; m_prev = '0; m_sy1 = '0; m_sy2 = '0;
      return;
    end
`ifdef PLIC_GATEWAY_SYNC_EN
    s = m_sy2;
    m_sy2 = m_sy1;
    m_sy1 = irq;
`else
    s = irq;
`endif
    m_req = '0;
    if (ovf_clr) m_ovf = '0;
    for (int i = 1; i < N; i++) begin
      r = s[i] && !m_prev[i];
      if (!tm[i]) begin
        fire = !m_busy[i] && s[i];
        owed[i] = 0;
      end else begin
        total = owed[i] + (r ? 1 : 0);
        fire = !m_busy[i] && (total > 0);
        if (fire) total = total - 1;
        if (total > CMAX) begin
          m_ovf[i] = 1'b1;
          total = CMAX;
        end
        owed[i] = total;
      end
      if (fire) m_busy[i] = 1'b1;
      else if (comp[i]) m_busy[i] = 1'b0;
      m_req[i] = fire;
    end
    m_prev = s;
  endtask

  task automatic cmp_vec(string name, logic [N-1:0] got, logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic chk(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    cmp_vec("req_o", req_o, m_req);
    cmp_vec("busy_o", busy_o, m_busy);
    cmp_vec("ovf_o", ovf_o, m_ovf);
    for (int i = 0; i < N; i++) if (req_o[i]) pulses[i]++;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    irq = '0; comp = '0; ovf_clr = 1'b0;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    for (int i = 0; i < N; i++) pulses[i] = 0;
  endtask

  task automatic edge_on(int src);
    irq[src] = 1'b1; run(1);
    irq[src] = 1'b0; run(1);
  endtask

  task automatic comp_pulse(int src, int settle);
    comp[src] = 1'b1; run(1);
    comp[src] = 1'b0; run(settle);
  endtask

  int lat;
  logic slow;

  initial begin
    for (int i = 0; i < N; i++) begin owed[i] = 0; pulses[i] = 0; end
    do_reset();
    chk("reset_req", int'(req_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_ovf", int'(ovf_o), 0);

    // Level source: pulse, re-request after completion, silence once low.
    tm = '0;
    irq[3] = 1'b1; run(4);
    chk("lvl_first_pulse", pulses[3], 1);
    chk("lvl_busy", int'(busy_o[3]), 1);
    comp_pulse(3, 4);
    chk("lvl_second_pulse", pulses[3], 2);
    irq[3] = 1'b0; run(4);
    comp_pulse(3, 5);
    chk("lvl_no_third", pulses[3], 2);
    chk("lvl_idle", int'(busy_o[3]), 0);

    // Edge burst: 3 edges while busy give exactly 3 further requests.
    do_reset();
    tm[5] = 1'b1;
    edge_on(5); run(3);
    chk("edge_first", pulses[5], 1);
    repeat (3) edge_on(5);
    run(3);
    chk("edge_held_busy", pulses[5], 1);
    repeat (3) comp_pulse(5, 4);
    chk("edge_burst_total", pulses[5], 4);
    comp_pulse(5, 5);
    chk("edge_silence", pulses[5], 4);
    chk("edge_idle", int'(busy_o[5]), 0);

    // Overflow: 17 edges while busy saturate at 15 and set the sticky flag.
    do_reset();
    tm[5] = 1'b1;
    edge_on(5); run(3);
    repeat (17) edge_on(5);
    run(3);
    chk("ovf_set", int'(ovf_o[5]), 1);
    ovf_clr = 1'b1; run(1); ovf_clr = 1'b0; run(1);
    chk("ovf_cleared", int'(ovf_o[5]), 0);
    repeat (15) comp_pulse(5, 3);
    chk("ovf_drain", pulses[5], 16);
    comp_pulse(5, 4);
    chk("ovf_drained_silent", pulses[5], 16);

    // Corner cases on source 7 and reserved slot 0.
    do_reset();
    tm = '0; tm[7] = 1'b1; tm[0] = 1'b1;
    comp_pulse(7, 2);
    chk("comp_idle_busy", int'(busy_o[7]), 0);
    chk("comp_idle_pulses", pulses[7], 0);
    edge_on(7); run(3);
    chk("corner_busy", int'(busy_o[7]), 1);
    irq[7] = 1'b1; comp[7] = 1'b1; run(1);
    comp[7] = 1'b0; irq[7] = 1'b0; run(5);
    chk("comp_rise_pulses", pulses[7], 2);
    chk("comp_rise_busy", int'(busy_o[7]), 1);
    for (int k = 0; k < 8; k++) begin irq[0] = ~irq[0]; comp[0] = irq[0]; run(1); end
    irq[0] = 1'b0; comp[0] = 1'b0;
    chk("slot0_pulses", pulses[0], 0);

    // Reset mid-operation with 2 edges pending.
    do_reset();
    tm[5] = 1'b1;
    edge_on(5); run(3);
    edge_on(5); edge_on(5); run(3);
    rst = 1'b1; run(1); rst = 1'b0;
    chk("rst_mid_req", int'(req_o), 0);
    chk("rst_mid_busy", int'(busy_o), 0);
    chk("rst_mid_ovf", int'(ovf_o), 0);
    pulses[5] = 0;
    run(6);
    chk("rst_mid_silent", pulses[5], 0);

    // Request latency from a rising input.
    do_reset();
    tm[9] = 1'b1;
    irq[9] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (req_o[9] && lat == 0) lat = k;
    end
    chk("latency", lat, LAT);
    irq[9] = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    slow = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        tm = $urandom;
        slow = $urandom_range(0, 1) == 1;
      end
      irq  = $urandom;
      comp = $urandom & $urandom & $urandom;
      if (slow) comp = comp & $urandom & $urandom & $urandom;
      ovf_clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) == 0);
      run(1);
    end
    rst = 1'b0; irq = '0; comp = '0; ovf_clr = 1'b0;
    run(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
